mod_counter: RTL and testbench

Parametrised modulo up/down counter for the clock datapath, the next generation of the per-digit-group counters (seconds, minutes, hours). Supports a configurable width and range, wrap or saturate at the limits, and cascading through a one-cycle carry/borrow pulse. Setup loads are range-checked and clamped. An optional registered BCD view drives the display decoder directly.

---
 rtl/mod_counter_if.sv | 44 ++++
 rtl/mod_counter.sv | 172 +++++++++++++++++
 tb/tb_mod_counter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for one mod_counter stage.
// Optional BCD digits are present only when MOD_COUNTER_BCD_EN is defined.
//   clear, load, load_data, count_en, up_down, sat_mode : controls into the counter
//   data, out_imp, at_max, at_min, load_err            : counter status
//   bcd_tens, bcd_ones                                  : decimal view of data (optional)
interface mod_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             count_en;
  logic             up_down;
  logic             sat_mode;
  logic [WIDTH-1:0] data;
  logic             out_imp;
  logic             at_max;
  logic             at_min;
  logic             load_err;
`ifdef MOD_COUNTER_BCD_EN
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;

  modport master (
    output clear, load, load_data, count_en, up_down, sat_mode,
    input  data, out_imp, at_max, at_min, load_err, bcd_tens, bcd_ones
  );

  modport slave (
    input  clear, load, load_data, count_en, up_down, sat_mode,
    output data, out_imp, at_max, at_min, load_err, bcd_tens, bcd_ones
  );
`else
  modport master (
    output clear, load, load_data, count_en, up_down, sat_mode,
    input  data, out_imp, at_max, at_min, load_err
  );

  modport slave (
    input  clear, load, load_data, count_en, up_down, sat_mode,
    output data, out_imp, at_max, at_min, load_err
  );
`endif
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter (MIN_VAL..MAX_VAL) with wrap or saturate,
// one-cycle carry/borrow pulse for cascading, and clamped setup loads.
// Optional macro MOD_COUNTER_BCD_EN adds registered BCD digits (needs MAX_VAL <= 99).
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mod_counter_if.slave (controls in, data/flags/pulses out)
module mod_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 59
) (
  input  logic         clock,
  input  logic         reset,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Parameter legality
  if (MIN_VAL >= MAX_VAL) begin : g_bad_range
    $error("mod_counter: MIN_VAL must be below MAX_VAL");
  end
  if ((64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_max
    $error("mod_counter: MAX_VAL does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] data_q, data_nxt;
  logic             imp_q, imp_nxt;
  logic             err_q, err_nxt;
  logic             data_lo, data_hi;
  logic             load_lo, load_hi;

  // Range compares; degenerate bounds are tied off to avoid constant compares
  if (MIN_VAL == 0) begin : g_min_zero
    assign data_lo = 1'b0;
    assign load_lo = 1'b0;
  end else begin : g_min_pos
    assign data_lo = (data_q < MIN_V);
    assign load_lo = (bus.load_data < MIN_V);
  end

  if (MAX_V == ALL_ONES) begin : g_max_full
    assign data_hi = 1'b0;
    assign load_hi = 1'b0;
  end else begin : g_max_part
    assign data_hi = (data_q > MAX_V);
    assign load_hi = (bus.load_data > MAX_V);
  end

  // Next count: clear > load > count > hold; limits checked before stepping
  always_comb begin
    data_nxt = data_q;
    imp_nxt  = 1'b0;
    err_nxt  = 1'b0;
    if (bus.clear) begin
      data_nxt = MIN_V;
    end else if (bus.load) begin
      if (load_hi) begin
        data_nxt = MAX_V;
        err_nxt  = 1'b1;
      end else if (load_lo) begin
        data_nxt = MIN_V;
        err_nxt  = 1'b1;
      end else begin
        data_nxt = bus.load_data;
      end
    end else if (bus.count_en) begin
      if (data_lo || data_hi) begin
        // Recover from an illegal state toward the limit in the count direction
        data_nxt = bus.up_down ? MIN_V : MAX_V;
      end else if (bus.up_down) begin
        if (data_q != MAX_V) begin
          data_nxt = data_q + WIDTH'(1);
        end else if (!bus.sat_mode) begin
          data_nxt = MIN_V;
          imp_nxt  = 1'b1;
        end
      end else begin
        if (data_q != MIN_V) begin
          data_nxt = data_q - WIDTH'(1);
        end else if (!bus.sat_mode) begin
          data_nxt = MAX_V;
          imp_nxt  = 1'b1;
        end
      end
    end
  end

  // Count state and pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= MIN_V;
      imp_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_nxt;
      imp_q  <= imp_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.data     = data_q;
  assign bus.out_imp  = imp_q;
  assign bus.load_err = err_q;
  assign bus.at_max   = (data_q == MAX_V);
  assign bus.at_min   = (data_q == MIN_V);

`ifdef MOD_COUNTER_BCD_EN
  if (MAX_VAL > 99) begin : g_bad_bcd
    $error("mod_counter: MOD_COUNTER_BCD_EN requires MAX_VAL <= 99");
  end

  function automatic logic [7:0] bcd_of(input logic [WIDTH-1:0] v);
    int unsigned vi;
    vi = 32'(v);
    return {4'(vi / 32'd10), 4'(vi % 32'd10)};
  endfunction

  localparam logic [7:0] BCD_MIN = bcd_of(MIN_V);

  logic [3:0] tens_q, tens_nxt;
  logic [3:0] ones_q, ones_nxt;
  logic       step_up, step_dn;

  // Plain single steps inside the range update digits incrementally
  assign step_up = bus.count_en && !bus.clear && !bus.load && !data_lo && !data_hi &&
                   bus.up_down && (data_q != MAX_V);
  assign step_dn = bus.count_en && !bus.clear && !bus.load && !data_lo && !data_hi &&
                   !bus.up_down && (data_q != MIN_V);

  // Digit update; wraps, forced limits, loads and clears recompute from data_nxt
  always_comb begin
    tens_nxt = tens_q;
    ones_nxt = ones_q;
    if (step_up) begin
      if (ones_q == 4'd9) begin
        ones_nxt = 4'd0;
        tens_nxt = tens_q + 4'd1;
      end else begin
        ones_nxt = ones_q + 4'd1;
      end
    end else if (step_dn) begin
      if (ones_q == 4'd0) begin
        ones_nxt = 4'd9;
        tens_nxt = tens_q - 4'd1;
      end else begin
        ones_nxt = ones_q - 4'd1;
      end
    end else if (bus.clear || bus.load || bus.count_en) begin
      {tens_nxt, ones_nxt} = bcd_of(data_nxt);
    end
  end

  // BCD digit registers
  always_ff @(posedge clock) begin
    if (reset) begin
      tens_q <= BCD_MIN[7:4];
      ones_q <= BCD_MIN[3:0];
    end else begin
      tens_q <= tens_nxt;
      ones_q <= ones_nxt;
    end
  end

  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: self-checking bench for mod_counter (0..59 main stage,
// 10..20 offset stage sharing its controls, and a seconds->minutes cascade).
// Checks the BCD digits as well when MOD_COUNTER_BCD_EN is defined.
module tb_mod_counter;

  typedef struct packed {
    logic       rst, clr, ld;
    logic [7:0] ldv;
    logic       en, ud, sat;
    logic [7:0] d;
    logic       imp, err;
  } stim_t;

  typedef struct packed {
    logic [7:0] d;
    logic       imp;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic [7:0] sd;
    logic       si;
    logic [7:0] md;
    logic       mi;
  } casc_t;

  logic  clock = 1'b0;
  logic  reset;
  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  sb [$];
  casc_t cq [$];

  always #5 clock = ~clock;

  mod_counter_if #(.WIDTH(8)) bus  ();
  mod_counter_if #(.WIDTH(8)) boff ();
  mod_counter_if #(.WIDTH(8)) bsec ();
  mod_counter_if #(.WIDTH(8)) bmin ();

  mod_counter #(.WIDTH(8), .MIN_VAL(0),  .MAX_VAL(59)) u_dut (.clock(clock), .reset(reset), .bus(bus));
  mod_counter #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(20)) u_off (.clock(clock), .reset(reset), .bus(boff));
  mod_counter #(.WIDTH(8), .MIN_VAL(0),  .MAX_VAL(59)) u_sec (.clock(clock), .reset(reset), .bus(bsec));
  mod_counter #(.WIDTH(8), .MIN_VAL(0),  .MAX_VAL(59)) u_min (.clock(clock), .reset(reset), .bus(bmin));

  // Offset stage mirrors the main controls
  assign boff.clear     = bus.clear;
  assign boff.load      = bus.load;
  assign boff.load_data = bus.load_data;
  assign boff.count_en  = bus.count_en;
  assign boff.up_down   = bus.up_down;
  assign boff.sat_mode  = bus.sat_mode;

  // Minutes stage steps on the seconds carry
  assign bmin.clear     = bsec.clear;
  assign bmin.load      = bsec.load;
  assign bmin.load_data = bsec.load_data;
  assign bmin.count_en  = bsec.out_imp;
  assign bmin.up_down   = bsec.up_down;
  assign bmin.sat_mode  = bsec.sat_mode;

  function automatic logic [7:0] bcd_of(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  task automatic drive_cycle(input stim_t s);
    reset         = s.rst;
    bus.clear     = s.clr;
    bus.load      = s.ld;
    bus.load_data = s.ldv;
    bus.count_en  = s.en;
    bus.up_down   = s.ud;
    bus.sat_mode  = s.sat;
    sb.push_back('{s.d, s.imp, s.err});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    stim_t st [5];
    exp_t  e;
    //        rst   clr   ld    ldv    en    ud    sat   d      imp   err
    st = '{'{1'b0, 1'b0, 1'b1, 8'd37, 1'b0, 1'b1, 1'b0, 8'd37, 1'b0, 1'b0},
           '{1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0},
           '{1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b1, 8'd59, 1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b0},
           '{1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.data !== e.d || bus.out_imp !== e.imp || bus.load_err !== e.err ||
          bus.at_max !== (e.d == 8'd59) || bus.at_min !== (e.d == 8'd0)
`ifdef MOD_COUNTER_BCD_EN
          || {bus.bcd_tens, bus.bcd_ones} !== bcd_of(e.d)
`endif
          ) begin
        n_fail++;
        $display("FAIL reset step %0d: got data=%0d imp=%b err=%b at_max=%b at_min=%b, need data=%0d imp=%b err=%b",
                 i, bus.data, bus.out_imp, bus.load_err, bus.at_max, bus.at_min, e.d, e.imp, e.err);
      end
    end
  endtask

  task automatic test_wrap_up();
    stim_t st [5];
    exp_t  e;
    st = '{'{1'b0, 1'b0, 1'b1, 8'd57, 1'b0, 1'b1, 1'b0, 8'd57, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd58, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd59, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.data !== e.d || bus.out_imp !== e.imp || bus.load_err !== e.err ||
          bus.at_max !== (e.d == 8'd59) || bus.at_min !== (e.d == 8'd0)
`ifdef MOD_COUNTER_BCD_EN
          || {bus.bcd_tens, bus.bcd_ones} !== bcd_of(e.d)
`endif
          ) begin
        n_fail++;
        $display("FAIL wrap_up step %0d: got data=%0d imp=%b err=%b at_max=%b at_min=%b, need data=%0d imp=%b err=%b",
                 i, bus.data, bus.out_imp, bus.load_err, bus.at_max, bus.at_min, e.d, e.imp, e.err);
      end
    end
  endtask

  task automatic test_wrap_down_sat();
    stim_t st [9];
    exp_t  e;
    st = '{'{1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd59, 1'b1, 1'b0},
           '{1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b1, 8'd59, 1'b0, 1'b1, 1'b1, 8'd59, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd59, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd59, 1'b0, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.data !== e.d || bus.out_imp !== e.imp || bus.load_err !== e.err ||
          bus.at_max !== (e.d == 8'd59) || bus.at_min !== (e.d == 8'd0)
`ifdef MOD_COUNTER_BCD_EN
          || {bus.bcd_tens, bus.bcd_ones} !== bcd_of(e.d)
`endif
          ) begin
        n_fail++;
        $display("FAIL wrap_down_sat step %0d: got data=%0d imp=%b err=%b at_max=%b at_min=%b, need data=%0d imp=%b err=%b",
                 i, bus.data, bus.out_imp, bus.load_err, bus.at_max, bus.at_min, e.d, e.imp, e.err);
      end
    end
  endtask

  task automatic test_load_clamp();
    stim_t st [5];
    exp_t  e;
    st = '{'{1'b0, 1'b0, 1'b1, 8'd75,  1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b1},
           '{1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b1, 8'd30,  1'b0, 1'b1, 1'b0, 8'd30, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b1},
           '{1'b0, 1'b0, 1'b1, 8'd60,  1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.data !== e.d || bus.out_imp !== e.imp || bus.load_err !== e.err ||
          bus.at_max !== (e.d == 8'd59) || bus.at_min !== (e.d == 8'd0)
`ifdef MOD_COUNTER_BCD_EN
          || {bus.bcd_tens, bus.bcd_ones} !== bcd_of(e.d)
`endif
          ) begin
        n_fail++;
        $display("FAIL load_clamp step %0d: got data=%0d imp=%b err=%b at_max=%b at_min=%b, need data=%0d imp=%b err=%b",
                 i, bus.data, bus.out_imp, bus.load_err, bus.at_max, bus.at_min, e.d, e.imp, e.err);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st [5];
    exp_t  e;
    st = '{'{1'b0, 1'b1, 1'b1, 8'd10, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b1, 1'b1, 8'd75, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b1, 8'd10, 1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd9,  1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd9,  1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.data !== e.d || bus.out_imp !== e.imp || bus.load_err !== e.err ||
          bus.at_max !== (e.d == 8'd59) || bus.at_min !== (e.d == 8'd0)
`ifdef MOD_COUNTER_BCD_EN
          || {bus.bcd_tens, bus.bcd_ones} !== bcd_of(e.d)
`endif
          ) begin
        n_fail++;
        $display("FAIL priority step %0d: got data=%0d imp=%b err=%b at_max=%b at_min=%b, need data=%0d imp=%b err=%b",
                 i, bus.data, bus.out_imp, bus.load_err, bus.at_max, bus.at_min, e.d, e.imp, e.err);
      end
    end
  endtask

  // Offset range 10..20: low clamp and back-to-back wrap pulses
  task automatic test_offset_range();
    stim_t st [7];
    exp_t  e;
    st = '{'{1'b0, 1'b0, 1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b1},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd20, 1'b1, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd10, 1'b1, 1'b0},
           '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd11, 1'b0, 1'b0},
           '{1'b0, 1'b0, 1'b1, 8'd25, 1'b0, 1'b1, 1'b0, 8'd20, 1'b0, 1'b1},
           '{1'b0, 1'b0, 1'b1, 8'd15, 1'b0, 1'b1, 1'b0, 8'd15, 1'b0, 1'b0},
           '{1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(st[i]);
      e = sb.pop_front();
      n_tests++;
      if (boff.data !== e.d || boff.out_imp !== e.imp || boff.load_err !== e.err ||
          boff.at_max !== (e.d == 8'd20) || boff.at_min !== (e.d == 8'd10)
`ifdef MOD_COUNTER_BCD_EN
          || {boff.bcd_tens, boff.bcd_ones} !== bcd_of(e.d)
`endif
          ) begin
        n_fail++;
        $display("FAIL offset step %0d: got data=%0d imp=%b err=%b at_max=%b at_min=%b, need data=%0d imp=%b err=%b",
                 i, boff.data, boff.out_imp, boff.load_err, boff.at_max, boff.at_min, e.d, e.imp, e.err);
      end
    end
  endtask

  // 59:59 + 1 second ripples to 00:00 over two cycles
  task automatic test_cascade();
    logic  ens [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    casc_t exps [5];
    casc_t e;
    int    min_pulses = 0;
    exps = '{'{8'd59, 1'b0, 8'd59, 1'b0},
             '{8'd0,  1'b1, 8'd59, 1'b0},
             '{8'd0,  1'b0, 8'd0,  1'b1},
             '{8'd0,  1'b0, 8'd0,  1'b0},
             '{8'd0,  1'b0, 8'd0,  1'b0}};
    for (int i = 0; i < 5; i++) begin
      reset          = 1'b0;
      bsec.clear     = 1'b0;
      bsec.load      = (i == 0);
      bsec.load_data = 8'd59;
      bsec.count_en  = ens[i];
      bsec.up_down   = 1'b1;
      bsec.sat_mode  = 1'b0;
      cq.push_back(exps[i]);
      @(posedge clock);
      #1;
      e = cq.pop_front();
      if (i > 0 && bmin.out_imp === 1'b1) min_pulses++;
      n_tests++;
      if (bsec.data !== e.sd || bsec.out_imp !== e.si || bmin.data !== e.md || bmin.out_imp !== e.mi) begin
        n_fail++;
        $display("FAIL cascade step %0d: got sec=%0d/%b min=%0d/%b, need sec=%0d/%b min=%0d/%b",
                 i, bsec.data, bsec.out_imp, bmin.data, bmin.out_imp, e.sd, e.si, e.md, e.mi);
      end
    end
    n_tests++;
    if (min_pulses !== 1) begin
      n_fail++;
      $display("FAIL cascade_min_pulses: got %0d, need 1", min_pulses);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_data  = 8'd0;
    bus.count_en   = 1'b0;
    bus.up_down    = 1'b1;
    bus.sat_mode   = 1'b0;
    bsec.clear     = 1'b0;
    bsec.load      = 1'b0;
    bsec.load_data = 8'd0;
    bsec.count_en  = 1'b0;
    bsec.up_down   = 1'b1;
    bsec.sat_mode  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_wrap_up();
    test_wrap_down_sat();
    test_load_clamp();
    test_priority();
    test_offset_range();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
